// File: rtl/absdiff_seq_4b.sv
// absdiff_seq_4b: multi-cycle 4-bit |a - b| unit.
// A four-state controller sequences a shared operand-register datapath.
// The datapath has a swap path and a subtractor.
// Operands arrive on a val/rdy input stream.
// The result leaves on a val/rdy output stream.
module absdiff_seq_4b (
  input  logic       clk,
  input  logic       rst,
  input  logic       istream_val,
  output logic       istream_rdy,
  input  logic [3:0] istream_msg_a,
  input  logic [3:0] istream_msg_b,
  output logic       ostream_val,
  input  logic       ostream_rdy,
  output logic [3:0] ostream_msg
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] SUB  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0] state_q, state_d;
  logic [3:0] a_q, a_d;
  logic [3:0] b_q, b_d;
  logic [3:0] alu_out;
  logic       a_sel, b_sel, alu_sel;
  logic       a_en, b_en;
  logic       lt;

  // Datapath: comparator, ALU mux and the register input muxes.
  always_comb begin
    lt      = (a_q < b_q);
    alu_out = alu_sel ? (a_q - b_q) : b_q;
    a_d     = a_sel ? alu_out : istream_msg_a;
    b_d     = b_sel ? a_q : istream_msg_b;
  end

  // Controller: next state, mux selects, register enables and Moore outputs.
  always_comb begin
    state_d     = state_q;
    a_sel       = 1'b0;
    b_sel       = 1'b0;
    alu_sel     = 1'b0;
    a_en        = 1'b0;
    b_en        = 1'b0;
    istream_rdy = 1'b0;
    ostream_val = 1'b0;
    case (state_q)
      IDLE: begin
        istream_rdy = 1'b1;
        if (istream_val) begin
          a_en    = 1'b1;
          b_en    = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        // Order the operands so the subtraction in SUB cannot underflow.
        if (lt) begin
          a_sel = 1'b1;
          b_sel = 1'b1;
          a_en  = 1'b1;
          b_en  = 1'b1;
        end
        state_d = SUB;
      end
      SUB: begin
        a_sel   = 1'b1;
        alu_sel = 1'b1;
        a_en    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        ostream_val = 1'b1;
        if (ostream_rdy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and operand registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      if (a_en) a_q <= a_d;
      if (b_en) b_q <= b_d;
    end
  end

  assign ostream_msg = a_q;

endmodule

// File: tb/tb_absdiff_seq_4b.sv
// Self-checking bench for absdiff_seq_4b.
// Runs directed cases and randomized operand pairs against a plain arithmetic model.
module tb_absdiff_seq_4b;

  logic       clk = 1'b0;
  logic       rst;
  logic       istream_val;
  logic       istream_rdy;
  logic [3:0] istream_msg_a;
  logic [3:0] istream_msg_b;
  logic       ostream_val;
  logic       ostream_rdy;
  logic [3:0] ostream_msg;

  int n_checks = 0;
  int n_fail   = 0;

  absdiff_seq_4b dut (
    .clk           (clk),
    .rst           (rst),
    .istream_val   (istream_val),
    .istream_rdy   (istream_rdy),
    .istream_msg_a (istream_msg_a),
    .istream_msg_b (istream_msg_b),
    .ostream_val   (ostream_val),
    .ostream_rdy   (ostream_rdy),
    .ostream_msg   (ostream_msg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  task automatic noise(input bit keep_val);
    istream_msg_a = 4'($urandom_range(15));
    istream_msg_b = 4'($urandom_range(15));
    istream_val   = keep_val ? 1'b1 : 1'($urandom_range(1));
  endtask

  // Enter at a negedge with the unit idle.
  // Leave at the negedge after the output has been taken.
  task automatic do_op(input int a, input int b, input int hold, input bit b2b);
    int exp;
    exp = ref_absdiff(a, b);
    check("idle_rdy", int'(istream_rdy), 1);
    check("idle_oval", int'(ostream_val), 0);
    istream_val   = 1'b1;
    istream_msg_a = 4'(a);
    istream_msg_b = 4'(b);
    ostream_rdy   = 1'($urandom_range(1));
    @(posedge clk);
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      // Stop asserting val so nothing is accepted when IDLE returns.
      // In back-to-back mode val stays high throughout.
      istream_msg_a = 4'($urandom_range(15));
      istream_msg_b = 4'($urandom_range(15));
      istream_val   = b2b;
      ostream_rdy   = 1'($urandom_range(1));
      check("busy_irdy", int'(istream_rdy), 0);
      check("busy_oval", int'(ostream_val), 0);
    end
    @(negedge clk);
    check("lat3_oval", int'(ostream_val), 1);
    check("lat3_msg", int'(ostream_msg), exp);
    check("done_irdy", int'(istream_rdy), 0);
    for (int h = 0; h < hold; h++) begin
      ostream_rdy   = 1'b0;
      istream_msg_a = 4'($urandom_range(15));
      istream_msg_b = 4'($urandom_range(15));
      @(negedge clk);
      check("bp_oval", int'(ostream_val), 1);
      check("bp_msg", int'(ostream_msg), exp);
      check("bp_irdy", int'(istream_rdy), 0);
    end
    ostream_rdy = 1'b1;
    @(negedge clk);
    ostream_rdy = 1'b0;
    check("after_oval", int'(ostream_val), 0);
    check("after_irdy", int'(istream_rdy), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst           = 1'b1;
    istream_val   = 1'b0;
    istream_msg_a = '0;
    istream_msg_b = '0;
    ostream_rdy   = 1'b0;
    #1;
    check("rst_irdy", int'(istream_rdy), 1);
    check("rst_oval", int'(ostream_val), 0);
    check("rst_msg", int'(ostream_msg), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    // A low istream_val in IDLE must not start anything.
    istream_val = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("idle_hold_rdy", int'(istream_rdy), 1);
      check("idle_hold_oval", int'(ostream_val), 0);
    end

    do_op(9, 3, 0, 1'b0);
    do_op(3, 9, 0, 1'b0);
    do_op(0, 15, 0, 1'b0);
    do_op(15, 0, 0, 1'b0);
    do_op(7, 7, 0, 1'b0);
    do_op(12, 5, 5, 1'b0);
    do_op(10, 4, 1, 1'b0);
    do_op(1, 2, 0, 1'b1);
    do_op(14, 3, 0, 1'b1);
    do_op(4, 13, 0, 1'b1);
    do_op(8, 8, 0, 1'b0);

    // Apply reset during SUB, between clock edges.
    istream_val   = 1'b1;
    istream_msg_a = 4'd14;
    istream_msg_b = 4'd1;
    @(posedge clk);
    @(negedge clk);
    istream_val = 1'b0;
    check("rm_calc_irdy", int'(istream_rdy), 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rm_irdy", int'(istream_rdy), 1);
    check("rm_oval", int'(ostream_val), 0);
    check("rm_msg", int'(ostream_msg), 0);
    @(negedge clk);
    rst         = 1'b0;
    ostream_rdy = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("rm_no_result", int'(ostream_val), 0);
    end
    ostream_rdy = 1'b0;
    do_op(2, 8, 0, 1'b0);

    for (int i = 0; i < 25; i++) begin
      do_op(int'($urandom_range(15)), int'($urandom_range(15)),
            int'($urandom_range(3)), 1'($urandom_range(1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
